// File: rtl/xga_sync_monitor.sv
// Receive-side XGA raster monitor: locks onto incoming sync/blank levels,
// regenerates hcount/vcount and reports lock, timing errors and frame starts.
module xga_sync_monitor #(
   parameter int unsigned X_VISIBLE_AREA = 1024,
   parameter int unsigned X_FRONT_PORCH  = 24,
   parameter int unsigned X_SYNC_PULSE   = 136,
   parameter int unsigned X_BACK_PORCH   = 160,
   parameter int unsigned Y_VISIBLE_AREA = 768,
   parameter int unsigned Y_FRONT_PORCH  = 3,
   parameter int unsigned Y_SYNC_PULSE   = 6,
   parameter int unsigned Y_BACK_PORCH   = 29,
   parameter int unsigned LOCK_FRAMES    = 2
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   output logic [10:0] hcount_rx,
   output logic [10:0] vcount_rx,
   output logic        locked,
   output logic        timing_err,
   output logic [7:0]  err_count,
   output logic        frame_start
);

   localparam int unsigned CNT_W    = 11;
   localparam int unsigned ERR_W    = 8;
   localparam int unsigned HTOT     = X_VISIBLE_AREA + X_FRONT_PORCH + X_SYNC_PULSE + X_BACK_PORCH;
   localparam int unsigned VTOT     = Y_VISIBLE_AREA + Y_FRONT_PORCH + Y_SYNC_PULSE + Y_BACK_PORCH;
   localparam int unsigned HS_START = X_VISIBLE_AREA + X_FRONT_PORCH;
   localparam int unsigned HS_END   = HS_START + X_SYNC_PULSE;
   localparam int unsigned VS_START = Y_VISIBLE_AREA + Y_FRONT_PORCH;
   localparam int unsigned VS_END   = VS_START + Y_SYNC_PULSE;
   localparam int unsigned FOK_W    = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      H_SYNC = 2'd1,
      VERIFY = 2'd2,
      LOCKED = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               hs_dly_q, hs_dly_d;
   logic               vs_dly_q, vs_dly_d;
   logic [CNT_W-1:0]   h_pos_q, h_pos_d;
   logic [CNT_W-1:0]   v_pos_q, v_pos_d;
   logic [FOK_W-1:0]   frames_ok_q, frames_ok_d;
   logic [CNT_W-1:0]   hcount_rx_q, hcount_rx_d;
   logic [CNT_W-1:0]   vcount_rx_q, vcount_rx_d;
   logic               locked_q, locked_d;
   logic               timing_err_q, timing_err_d;
   logic [ERR_W-1:0]   err_count_q, err_count_d;
   logic               frame_start_q, frame_start_d;

   logic               hs_rise, vs_rise;
   logic               h_wrap;
   logic [CNT_W-1:0]   h_adv, v_adv;
   logic               exp_hs, exp_vs, exp_hb, exp_vb;
   logic               mismatch;
   logic [FOK_W:0]     frames_inc;
   logic [ERR_W-1:0]   err_inc;

   // Edge detection, default raster advance and predicted levels
   always_comb begin
      hs_rise  = hsync_in & ~hs_dly_q;
      vs_rise  = vsync_in & ~vs_dly_q;
      h_wrap   = (h_pos_q == CNT_W'(HTOT - 1));
      h_adv    = h_wrap ? '0 : h_pos_q + CNT_W'(1);
      v_adv    = v_pos_q;
      if (h_wrap) begin
         v_adv = (v_pos_q == CNT_W'(VTOT - 1)) ? '0 : v_pos_q + CNT_W'(1);
      end
      exp_hs   = (h_pos_q >= CNT_W'(HS_START)) && (h_pos_q < CNT_W'(HS_END));
      exp_vs   = (v_pos_q >= CNT_W'(VS_START)) && (v_pos_q < CNT_W'(VS_END));
      exp_hb   = (h_pos_q >= CNT_W'(X_VISIBLE_AREA));
      exp_vb   = (v_pos_q >= CNT_W'(Y_VISIBLE_AREA));
      mismatch = (hsync_in != exp_hs) || (vsync_in != exp_vs) ||
                 (hblnk_in != exp_hb) || (vblnk_in != exp_vb);
      frames_inc = (FOK_W + 1)'(frames_ok_q) + (FOK_W + 1)'(1);
      err_inc    = (err_count_q == {ERR_W{1'b1}}) ? err_count_q : err_count_q + ERR_W'(1);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      hs_dly_d      = hsync_in;
      vs_dly_d      = vsync_in;
      h_pos_d       = h_adv;
      v_pos_d       = v_adv;
      frames_ok_d   = frames_ok_q;
      err_count_d   = err_count_q;
      timing_err_d  = 1'b0;
      frame_start_d = 1'b0;
      hcount_rx_d   = h_pos_q;
      vcount_rx_d   = v_pos_q;

      case (state_q)
         HUNT: begin
            if (hs_rise) begin
               h_pos_d = CNT_W'(HS_START + 1);
               state_d = H_SYNC;
            end
         end
         H_SYNC: begin
            if (hs_rise && (h_pos_q != CNT_W'(HS_START))) begin
               state_d = HUNT;
            end else if (vs_rise) begin
               // vsync must rise on the first pixel of a line to be trusted
               if (h_pos_q == '0) begin
                  v_pos_d     = CNT_W'(VS_START);
                  frames_ok_d = '0;
                  state_d     = VERIFY;
               end else begin
                  state_d = HUNT;
               end
            end
         end
         VERIFY: begin
            if (mismatch) begin
               state_d = HUNT;
            end else if (vs_rise) begin
               frames_ok_d = frames_inc[FOK_W-1:0];
               if (frames_inc == (FOK_W + 1)'(LOCK_FRAMES)) begin
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (mismatch) begin
               timing_err_d = 1'b1;
               err_count_d  = err_inc;
               state_d      = HUNT;
            end else if ((h_pos_q == '0) && (v_pos_q == '0)) begin
               frame_start_d = 1'b1;
            end
         end
         default: state_d = HUNT;
      endcase

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q       <= HUNT;
         hs_dly_q      <= 1'b0;
         vs_dly_q      <= 1'b0;
         h_pos_q       <= '0;
         v_pos_q       <= '0;
         frames_ok_q   <= '0;
         hcount_rx_q   <= '0;
         vcount_rx_q   <= '0;
         locked_q      <= 1'b0;
         timing_err_q  <= 1'b0;
         err_count_q   <= '0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hs_dly_q      <= hs_dly_d;
         vs_dly_q      <= vs_dly_d;
         h_pos_q       <= h_pos_d;
         v_pos_q       <= v_pos_d;
         frames_ok_q   <= frames_ok_d;
         hcount_rx_q   <= hcount_rx_d;
         vcount_rx_q   <= vcount_rx_d;
         locked_q      <= locked_d;
         timing_err_q  <= timing_err_d;
         err_count_q   <= err_count_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hcount_rx   = hcount_rx_q;
   assign vcount_rx   = vcount_rx_q;
   assign locked      = locked_q;
   assign timing_err  = timing_err_q;
   assign err_count   = err_count_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_xga_sync_monitor.sv
// Bench for xga_sync_monitor on a shrunken 8x5 raster so several relocks fit in a short run.
module tb_xga_sync_monitor;

   localparam int XV = 4, XF = 1, XS = 2, XB = 1;
   localparam int YV = 2, YF = 1, YS = 1, YB = 1;
   localparam int LOCKF = 2;
   localparam int HTOT = XV + XF + XS + XB;
   localparam int VTOT = YV + YF + YS + YB;
   localparam int HS_START = XV + XF;
   localparam int HS_END = HS_START + XS;
   localparam int VS_START = YV + YF;
   localparam int VS_END = VS_START + YS;

   logic        pclk;
   logic        rst;
   logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [10:0] hcount_rx, vcount_rx;
   logic        locked, timing_err, frame_start;
   logic [7:0]  err_count;

   xga_sync_monitor #(
      .X_VISIBLE_AREA(XV), .X_FRONT_PORCH(XF), .X_SYNC_PULSE(XS), .X_BACK_PORCH(XB),
      .Y_VISIBLE_AREA(YV), .Y_FRONT_PORCH(YF), .Y_SYNC_PULSE(YS), .Y_BACK_PORCH(YB),
      .LOCK_FRAMES(LOCKF)
   ) dut (
      .pclk(pclk), .rst(rst),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .hcount_rx(hcount_rx), .vcount_rx(vcount_rx),
      .locked(locked), .timing_err(timing_err), .err_count(err_count),
      .frame_start(frame_start)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int checks = 0;
   int failures = 0;

   // Source generator position of the next sample to drive
   int hc = 0, vc = 0;
   int s_next = 0, s_drv = -1;
   bit model_en = 1'b1;

   // Model: lock is earned by one hsync rise, then a vsync rise, then LOCKF more vsync rises
   bit m_locked = 1'b0;
   int m_stage = 0;
   int m_vsr = 0;
   int m_err = 0;
   bit prev_hs = 1'b0, prev_vs = 1'b0;

   bit nxt_valid = 1'b0, nxt_locked = 1'b0, nxt_terr = 1'b0, nxt_fs = 1'b0;
   int nxt_err = 0, nxt_hc = 0, nxt_vc = 0;
   bit exp_valid = 1'b0, exp_locked = 1'b0, exp_terr = 1'b0, exp_fs = 1'b0;
   int exp_err = 0, exp_hc = 0, exp_vc = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (sample %0d)", name, act, exp, s_drv);
      end
   endtask

   function automatic logic [3:0] clean_lv(input int h, input int v);
      logic [3:0] lv;
      lv[3] = (h >= HS_START) && (h < HS_END);
      lv[2] = (v >= VS_START) && (v < VS_END);
      lv[1] = (h >= XV);
      lv[0] = (v >= YV);
      return lv;
   endfunction

   // Drive one sample (optionally forced levels), update the model, wait for the next sample point
   task automatic step(input bit do_rst, input bit frc, input logic [3:0] flv);
      logic [3:0] clv, dlv;
      bit rh, rv;
      @(posedge pclk);
      #1;
      exp_valid = nxt_valid; exp_locked = nxt_locked; exp_terr = nxt_terr;
      exp_fs = nxt_fs; exp_err = nxt_err; exp_hc = nxt_hc; exp_vc = nxt_vc;
      clv = clean_lv(hc, vc);
      dlv = frc ? flv : clv;
      rst = do_rst;
      {hsync_in, vsync_in, hblnk_in, vblnk_in} = dlv;
      nxt_valid = model_en;
      nxt_terr = 1'b0;
      nxt_fs = 1'b0;
      if (do_rst) begin
         m_locked = 1'b0; m_stage = 0; m_err = 0;
         prev_hs = 1'b0; prev_vs = 1'b0;
         nxt_hc = 0; nxt_vc = 0;
      end else begin
         rh = dlv[3] && !prev_hs;
         rv = dlv[2] && !prev_vs;
         if (m_locked) begin
            if (dlv != clv) begin
               m_locked = 1'b0; m_stage = 0; nxt_terr = 1'b1;
               m_err = (m_err < 255) ? m_err + 1 : 255;
            end else if (hc == 0 && vc == 0) begin
               nxt_fs = 1'b1;
            end
         end else if (m_stage == 0) begin
            if (rh) m_stage = 1;
         end else if (m_stage == 1) begin
            if (rv) begin m_stage = 2; m_vsr = 0; end
         end else if (rv) begin
            m_vsr++;
            if (m_vsr == LOCKF) begin m_locked = 1'b1; m_stage = 0; end
         end
         prev_hs = dlv[3];
         prev_vs = dlv[2];
         nxt_hc = hc;
         nxt_vc = vc;
         s_drv = s_next;
         s_next++;
         hc++;
         if (hc == HTOT) begin
            hc = 0;
            vc = (vc == VTOT - 1) ? 0 : vc + 1;
         end
      end
      nxt_locked = m_locked;
      nxt_err = m_err;
      @(negedge pclk);
   endtask

   // Per-cycle comparison against the model
   always @(negedge pclk) begin
      if (exp_valid) begin
         chk("locked", int'(locked), int'(exp_locked));
         chk("timing_err", int'(timing_err), int'(exp_terr));
         chk("err_count", int'(err_count), exp_err);
         chk("frame_start", int'(frame_start), int'(exp_fs));
         if (exp_locked) begin
            chk("hcount_rx", int'(hcount_rx), exp_hc);
            chk("vcount_rx", int'(vcount_rx), exp_vc);
         end
      end
   end

   task automatic wait_pos(input int h, input int v, input int max);
      int n = 0;
      while (!(locked && hc == h && vc == v) && n < max) begin
         step(1'b0, 1'b0, 4'h0);
         n++;
      end
      chk("pos_reached", int'(locked && hc == h && vc == v), 1);
   endtask

   task automatic wait_lock(input int max);
      int n = 0;
      while (!locked && n < max) begin
         step(1'b0, 1'b0, 4'h0);
         n++;
      end
      chk("relock", int'(locked), 1);
   endtask

   initial begin
      int n, s_g, s0, t_seen, fs_cnt;
      int fs_at[2];
      logic [10:0] hs_seq;
      rst = 1'b1;
      {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'h0;

      step(1'b1, 1'b0, 4'h0);
      step(1'b1, 1'b0, 4'h0);
      step(1'b0, 1'b0, 4'h0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_err_count", int'(err_count), 0);
      chk("rst_hcount", int'(hcount_rx), 0);
      chk("rst_vcount", int'(vcount_rx), 0);

      // Clean source from sample 0: lock on sample 3*8 + 2*40 = 104, visible one cycle later
      n = 0;
      while (!locked && n < 400) begin step(1'b0, 1'b0, 4'h0); n++; end
      chk("first_lock_sample", s_drv, 105);

      fs_at[0] = -1; fs_at[1] = -1; fs_cnt = 0; n = 0;
      while (fs_cnt < 2 && n < 200) begin
         step(1'b0, 1'b0, 4'h0);
         n++;
         if (frame_start) begin fs_at[fs_cnt] = s_drv; fs_cnt++; end
      end
      chk("frame_start_1", fs_at[0], 121);
      chk("frame_start_2", fs_at[1], 161);

      // hsync one pixel early
      wait_pos(HS_START - 1, 1, 100);
      step(1'b0, 1'b1, clean_lv(HS_START - 1, 1) | 4'b1000);
      s_g = s_drv;
      step(1'b0, 1'b0, 4'h0);
      chk("early_hs_terr", int'(timing_err), 1);
      chk("early_hs_locked", int'(locked), 0);
      chk("early_hs_errcnt", int'(err_count), 1);
      n = 0;
      while (!locked && n < 300) begin step(1'b0, 1'b0, 4'h0); n++; end
      chk("early_hs_relock_delay", s_drv - s_g, 93);
      chk("early_hs_errcnt_hold", int'(err_count), 1);

      // vblnk inverted for one visible sample
      wait_pos(2, 1, 100);
      step(1'b0, 1'b1, clean_lv(2, 1) ^ 4'b0001);
      step(1'b0, 1'b0, 4'h0);
      chk("vblnk_terr", int'(timing_err), 1);
      chk("vblnk_errcnt", int'(err_count), 2);
      chk("vblnk_locked", int'(locked), 0);
      step(1'b0, 1'b0, 4'h0);
      chk("vblnk_terr_pulse", int'(timing_err), 0);
      wait_lock(300);

      // Source drops to all-zero levels at (0,0): first disagreement is hblnk at h=4
      wait_pos(0, 0, 100);
      s0 = s_next;
      t_seen = -1;
      repeat (2 * HTOT) begin
         step(1'b0, 1'b1, 4'h0);
         if (timing_err && t_seen < 0) t_seen = s_drv;
      end
      chk("zeros_terr_delay", t_seen - s0, 5);
      chk("zeros_errcnt", int'(err_count), 3);
      wait_lock(300);

      // 300 lock losses saturate the counter
      repeat (300) begin
         wait_pos(0, VS_START - 1, 200);
         step(1'b0, 1'b1, clean_lv(0, VS_START - 1) ^ 4'b0001);
      end
      step(1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b0, 4'h0);
      chk("errcnt_saturated", int'(err_count), 255);
      wait_lock(300);

      // Reset while locked
      wait_pos(0, 1, 100);
      step(1'b1, 1'b0, 4'h0);
      step(1'b0, 1'b0, 4'h0);
      chk("midrst_locked", int'(locked), 0);
      chk("midrst_terr", int'(timing_err), 0);
      chk("midrst_errcnt", int'(err_count), 0);
      chk("midrst_hcount", int'(hcount_rx), 0);
      chk("midrst_vcount", int'(vcount_rx), 0);
      chk("midrst_fs", int'(frame_start), 0);
      wait_lock(300);

      // Misplaced hsync rise while in H_SYNC returns to HUNT (observed via the h resync)
      model_en = 1'b0;
      step(1'b1, 1'b0, 4'h0);
      hs_seq = 11'b00100100100;
      for (int i = 0; i < 11; i++) begin
         step(1'b0, 1'b1, {hs_seq[i], 3'b000});
         if (i == 3) chk("hsync_hunt_h3", int'(hcount_rx), 2);
         if (i == 4) chk("hsync_resync_h", int'(hcount_rx), HS_START + 1);
         if (i == 9) chk("hsync_after_bad", int'(hcount_rx), 3);
         if (i == 10) chk("hsync_reresync", int'(hcount_rx), HS_START + 1);
      end
      chk("hsync_bad_terr", int'(timing_err), 0);
      chk("hsync_bad_locked", int'(locked), 0);
      chk("hsync_bad_errcnt", int'(err_count), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
